pipelined_barrel_shifter: RTL
=============================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 SHALL have parameter N, default 8, data width in bits; legal values are powers of two from 2 to 64.
REQ-002 SHALL have derived localparam SW = $clog2(N), the shift-amount width, which is also the pipeline depth.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port up_valid, input, 1 bit, input transfer request.
REQ-006 SHALL have port up_ready, output, 1 bit, the block accepts input this cycle.
REQ-007 SHALL have port up_data, input, N bits, operand.
REQ-008 SHALL have port up_amount, input, SW bits, shift distance 0..N-1.
REQ-009 SHALL have port up_op, input, 2 bits: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
REQ-010 SHALL have port down_valid, output, 1 bit, result available.
REQ-011 SHALL have port down_ready, input, 1 bit, consumer accepts the result.
REQ-012 SHALL have port down_data, output, N bits, shifted result.

Function
REQ-013 SHALL implement SW register stages; stage k applies a shift of 2^k when amount bit k is 1, otherwise it passes the data unchanged.
REQ-014 SHALL carry valid, data, op and the remaining amount bits through every stage.
REQ-015 SHALL fill vacated bits with 0 for ops 00 and 01, and with a copy of operand bit N-1 for op 10.
REQ-016 SHALL, for op 11, move the bits shifted out at bit 0 into the MSB end (with ROTATE_EN defined).
REQ-017 SHALL have a latency of exactly SW cycles from an accepted input to down_valid with no backpressure.
REQ-018 SHALL sustain one result per cycle while down_ready is held at 1.
REQ-019 SHALL define advance = !down_valid || down_ready; SHALL drive up_ready = advance.
REQ-020 SHALL treat an input transfer as up_valid && up_ready, and an output transfer as down_valid && down_ready.
REQ-021 SHALL advance all stages together when advance=1 and hold all stages when advance=0; bubbles are not collapsed.
REQ-022 SHALL keep down_data and down_valid stable while down_valid=1 and down_ready=0.
REQ-023 SHALL load a bubble (valid=0) into stage 0 when advance=1 and up_valid=0.
REQ-024 SHALL produce down_data equal to up_data for up_amount=0, for every op.
REQ-025 SHALL never drop or duplicate a transaction; results leave in acceptance order.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear all stage valid bits, data, op and amount registers to 0.
REQ-027 SHALL drive down_valid=0, down_data=0 and up_ready=1 during reset.
REQ-028 SHALL discard transactions in flight when reset is asserted mid-operation; none emerge after release.
REQ-029 SHALL accept input on the first rising clk edge after rst_n deasserts.

Configuration
REQ-030 SHALL, when macro PIPELINED_BARREL_SHIFTER_ROTATE_EN is defined, implement op 11 as rotate right.
REQ-031 SHALL, when that macro is undefined, treat op 11 as logical right (same as op 01), with no rotate logic synthesized.

Verification
REQ-032 SHALL pass this scenario (N=8): data 8'b1011_0011, amount 3, op 00, down_ready=1 -> 8'b1001_1000 after exactly 3 cycles.
REQ-033 SHALL pass this scenario (N=8): data 8'b1011_0011, amount 3, op 10 -> 8'b1111_0110; with op 01 -> 8'b0001_0110.
REQ-034 SHALL pass this scenario (N=8, macro defined): data 8'b1011_0011, amount 3, op 11 -> 8'b0111_0110; with macro undefined -> 8'b0001_0110.
REQ-035 SHALL pass this scenario: 8 back-to-back inputs (amount 0..7), down_ready=1 -> 8 results on 8 consecutive cycles, in order, each matching the reference model.
REQ-036 SHALL pass this scenario: down_ready=0 for 5 cycles while a result is pending -> up_ready=0 and down_data held; on release, no loss or duplication.
REQ-037 SHALL pass this scenario: rst_n pulsed low with 2 transactions in flight -> down_valid=0 immediately; no stale result appears after release.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, with valid/ready flow control.
// Define PIPELINED_BARREL_SHIFTER_ROTATE_EN to make op 11 a rotate right; otherwise op 11 acts as logical right.
module pipelined_barrel_shifter #(
    parameter  int unsigned N  = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_amount,
    input  logic [1:0]    up_op,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data
);

    logic          advance;
    logic [SW-1:0] valid_q, valid_d;
    logic [N-1:0]  data_q [SW];
    logic [N-1:0]  data_d [SW];
    logic [1:0]    op_q   [SW];
    logic [1:0]    op_d   [SW];
    logic [SW-1:0] amt_q  [SW];
    logic [SW-1:0] amt_d  [SW];

    // Shift by a fixed distance s; arithmetic right keeps replicating the original sign bit.
    function automatic logic [N-1:0] shift_step(input logic [N-1:0] d, input logic [1:0] op,
                                                input int unsigned s);
        logic [N-1:0] r;
        case (op)
            2'b00:   r = d << s;
            2'b10:   r = N'($signed(d) >>> s);
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
            2'b11:   r = (d >> s) | (d << (N - s));
`endif
            default: r = d >> s;
        endcase
        return r;
    endfunction

    // All stages move together; a stalled output freezes the whole pipe.
    always_comb begin
        advance = !valid_q[SW-1] || down_ready;
        valid_d = valid_q;
        data_d  = data_q;
        op_d    = op_q;
        amt_d   = amt_q;
        if (advance) begin
            valid_d[0] = up_valid;
            data_d[0]  = up_amount[0] ? shift_step(up_data, up_op, 32'd1) : up_data;
            op_d[0]    = up_op;
            amt_d[0]   = up_amount;
            for (int k = 1; k < SW; k++) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = amt_q[k-1][k] ? shift_step(data_q[k-1], op_q[k-1], 32'd1 << k)
                                           : data_q[k-1];
                op_d[k]    = op_q[k-1];
                amt_d[k]   = amt_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < SW; k++) begin
                data_q[k] <= '0;
                op_q[k]   <= '0;
                amt_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
        end
    end

    assign up_ready   = advance;
    assign down_valid = valid_q[SW-1];
    assign down_data  = data_q[SW-1];

endmodule
